tx_framer: RTL and testbench

//  Upstream feeder for the TX shift stage. Buffers bytes from the host in a small FIFO,

---
 rtl/tx_framer.sv | 139 +++++++++++++
 tb/tb_tx_framer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
`default_nettype none
// ============================================================================
// Module  : tx_framer
// Brief   : Byte FIFO plus 11-bit frame builder feeding a TX shifter via an
//           Enable/Done handshake. Macro TX_FRAMER_PARITY_EN enables parity;
//           without it, bit 9 becomes a second stop bit.
// Revision: 1.0
// ============================================================================
module tx_framer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          i_Pclk,
    input  logic          i_Rst_n,
    input  logic          i_Wr_Valid,
    input  logic [7:0]    i_Wr_Data,
    output logic          o_Wr_Ready,
    input  logic          i_Parity_Odd,
    output logic          o_Enable,
    output logic [10:0]   o_Data,
    input  logic          i_Done,
    output logic          o_Busy,
    output logic [AW:0]   o_Count,
    output logic          o_Frame_Done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q;
    logic          enable_q, enable_d;
    logic [10:0]   data_q, data_d;
    logic          frame_done_q, frame_done_d;

    logic          wr_en;
    logic          pop;
    logic          done_evt;
    logic [7:0]    head;
    logic          bit9;

    assign head     = mem_q[rd_ptr_q];
    assign done_evt = i_Done & ~done_q;
    assign wr_en    = i_Wr_Valid & (count_q != C_FULL);
    assign pop      = (state_q == ST_IDLE) & (count_q != '0);

`ifdef TX_FRAMER_PARITY_EN
    assign bit9 = ^head ^ i_Parity_Odd;
`else
    logic unused_parity;
    assign unused_parity = i_Parity_Odd;
    assign bit9          = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        enable_d     = 1'b0;
        data_d       = data_q;
        frame_done_d = 1'b0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    data_d   = {1'b1, bit9, head, 1'b0};
                    enable_d = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // Only a rising Done while a frame is in flight closes it.
                if (done_evt) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            enable_q     <= 1'b0;
            data_q       <= 11'h7FF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            done_q       <= i_Done;
            enable_q     <= enable_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge i_Pclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Wr_Data;
        end
    end

    assign o_Wr_Ready   = (count_q != C_FULL);
    assign o_Enable     = enable_q;
    assign o_Data       = data_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Count      = count_q;
    assign o_Busy       = (state_q != ST_IDLE) | (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_tx_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_framer
// Brief   : Self-checking bench for tx_framer against a queue-based frame model.
// Revision: 1.0
// ============================================================================
module tb_tx_framer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          parity_odd;
    logic          enable;
    logic [10:0]   data;
    logic          done;
    logic          busy;
    logic [AW:0]   count;
    logic          frame_done;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: FIFO contents as a queue, plus where the current frame is.
    byte unsigned  m_q[$];
    int            m_phase;       // 0 no frame, 1 just loaded, 2 on the wire
    logic          m_prev_done;
    logic          m_en;
    logic [10:0]   m_data;
    logic          m_fd;
    int            frames_seen;

    always #5 clk = ~clk;

    tx_framer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_Pclk       (clk),
        .i_Rst_n      (rst_n),
        .i_Wr_Valid   (wr_valid),
        .i_Wr_Data    (wr_data),
        .o_Wr_Ready   (wr_ready),
        .i_Parity_Odd (parity_odd),
        .o_Enable     (enable),
        .o_Data       (data),
        .i_Done       (done),
        .o_Busy       (busy),
        .o_Count      (count),
        .o_Frame_Done (frame_done)
    );

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic odd);
        logic p;
`ifdef TX_FRAMER_PARITY_EN
        p = (^b) ^ odd;
`else
        p = 1'b1;
`endif
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_phase     = 0;
        m_prev_done = 1'b0;
        m_en        = 1'b0;
        m_data      = 11'h7FF;
        m_fd        = 1'b0;
    endtask

    task automatic check_outputs();
        chk("enable",     {31'd0, enable},      {31'd0, m_en});
        chk("data",       {21'd0, data},        {21'd0, m_data});
        chk("frame_done", {31'd0, frame_done},  {31'd0, m_fd});
        chk("count",      {29'd0, count},       m_q.size());
        chk("wr_ready",   {31'd0, wr_ready},    {31'd0, m_q.size() < DEPTH});
        chk("busy",       {31'd0, busy},        {31'd0, (m_phase != 0) || (m_q.size() != 0)});
    endtask

    // One clock: drive inputs, advance the model by the same edge, compare.
    task automatic step(input logic wv, input logic [7:0] wd, input logic odd, input logic dn);
        int   n;
        logic evt;
        @(negedge clk);
        wr_valid   = wv;
        wr_data    = wd;
        parity_odd = odd;
        done       = dn;
        @(posedge clk);
        n           = m_q.size();
        evt         = dn & ~m_prev_done;
        m_prev_done = dn;
        m_en        = 1'b0;
        m_fd        = 1'b0;
        if (m_phase == 0 && n != 0) begin
            m_data  = make_frame(m_q.pop_front(), odd);
            m_en    = 1'b1;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && evt) begin
            m_fd    = 1'b1;
            m_phase = 0;
            frames_seen++;
        end
        if (wv && n < DEPTH) m_q.push_back(wd);
        #1;
        check_outputs();
    endtask

    // Acknowledge frames with Done pulses until the model drains; bounded.
    task automatic drain(input logic odd);
        int cyc;
        cyc = 0;
        while ((m_q.size() != 0 || m_phase != 0) && cyc < 200) begin
            step(1'b0, 8'h00, odd, (cyc % 4) == 3);
            cyc++;
        end
        chk("drain_timeout", {31'd0, cyc < 200}, 32'd1);
    endtask

    initial begin
        logic [7:0] bytes4 [4];
        logic       dlev;
        bytes4 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        frames_seen = 0;
        rst_n      = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        parity_odd = 1'b0;
        done       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte, odd parity; load pulse lands the edge after acceptance.
        step(1'b1, 8'h0D, 1'b1, 1'b0);
        chk("lat_no_enable_yet", {31'd0, enable}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("lat_enable", {31'd0, enable}, 32'd1);
`ifdef TX_FRAMER_PARITY_EN
        chk("frame_0D_odd", {21'd0, data}, {21'd0, 11'b10000011010});
`else
        chk("frame_0D_odd", {21'd0, data}, {21'd0, 11'b11000011010});
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1);   // held level must not count twice

        // Same byte, even parity.
        step(1'b1, 8'h0D, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("frame_0D_even", {21'd0, data}, {21'd0, 11'b11000011010});
        drain(1'b0);

        // Fill while a frame is in flight; fifth write is dropped.
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, bytes4[i], 1'b1, 1'b0);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_not_ready", {31'd0, wr_ready}, 32'd0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("drop_count", {29'd0, count}, 32'd4);
        drain(1'b1);
        chk("idle_after_burst", {31'd0, busy}, 32'd0);

        // Simultaneous write and pop with two queued.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("pre_same_edge", {29'd0, count}, 32'd2);
        step(1'b1, 8'h44, 1'b0, 1'b1);
        chk("same_edge_count", {29'd0, count}, 32'd2);
        chk("same_edge_load", {31'd0, enable}, 32'd1);

        // Asynchronous reset mid-frame with entries queued.
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, i[0]);

        // Random traffic with a randomly toggling Done level.
        dlev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) dlev = ~dlev;
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), dlev);
        end
        drain(1'b0);
        chk("frames_seen_nonzero", {31'd0, frames_seen > 10}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
